coherent_bus_arbiter: RTL

Parametrised round-robin arbiter for the shared coherence bus between the per-processor data-cache wrappers and memory. It generalises the fixed 8-processor/4-snoop arbiter to NUM_PROC processor channels and NUM_SNOOP snoop channels. It adds registered round-robin fairness, nested snoop arbitration inside an owning processor transaction, an owner-ID output, and an optional hold-timeout watchdog.

---
 rtl/coherent_bus_arbiter_pkg.sv | 20 ++
 rtl/coherent_bus_arbiter_rr_picker.sv | 39 +++
 rtl/coherent_bus_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/coherent_bus_arbiter_pkg.sv
// Shared types for the coherence-bus arbiter: FSM state encoding, bus-turnaround
// length and the index-width helper used to size pointers and owner IDs.
package coherent_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PROC,
    PROC_SNOOP,
    PROC_MEM,
    TURN
  } arb_state_t;

  localparam int TURN_CYCLES = 1;

  // Width of an index into n channels; a single channel still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/coherent_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit at or after ptr, cyclically.
// Zero latency; no flow control, the caller decides when the pick is used.
module rr_picker
  import coherent_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]        req,
  input  logic [idx_w(WIDTH)-1:0] ptr,
  output logic [WIDTH-1:0]        gnt_onehot,
  output logic [idx_w(WIDTH)-1:0] gnt_idx,
  output logic                    any
);

  localparam int IW = idx_w(WIDTH);

  int              pos;
  logic [IW-1:0]   pos_idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    pos        = 0;
    pos_idx    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      // ptr is always kept below WIDTH, so one subtraction wraps the scan
      pos = int'(ptr) + i;
      if (pos >= WIDTH) pos = pos - WIDTH;
      pos_idx = IW'(pos);
      if (!any && req[pos_idx]) begin
        any                 = 1'b1;
        gnt_onehot[pos_idx] = 1'b1;
        gnt_idx             = pos_idx;
      end
    end
  end

endmodule

// File: rtl/coherent_bus_arbiter.sv
// Round-robin coherence-bus arbiter: processor ownership with nested snoop/memory data-supply grants.
// Requests are registered first, so grants follow a request edge by two clocks; owners are never pre-empted.
// Optional hold watchdog (MAX_HOLD cycles) compiled in with COHERENT_ARB_TIMEOUT_EN.
module coherent_bus_arbiter
  import coherent_arb_pkg::*;
#(
  parameter int NUM_PROC  = 8,
  parameter int NUM_SNOOP = 4,
  parameter int MAX_HOLD  = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PROC-1:0]         proc_req,
  output logic [NUM_PROC-1:0]         proc_gnt,
  input  logic [NUM_SNOOP-1:0]        snoop_req,
  output logic [NUM_SNOOP-1:0]        snoop_gnt,
  input  logic                        mem_snoop_req,
  output logic                        mem_snoop_gnt,
  output logic                        bus_busy,
  output logic [$clog2(NUM_PROC)-1:0] owner_id,
  output logic                        hold_timeout
);

  localparam int PW = idx_w(NUM_PROC);
  localparam int SW = idx_w(NUM_SNOOP);
  localparam int TW = idx_w(TURN_CYCLES);

  if (NUM_PROC < 2 || NUM_PROC > 16 || NUM_SNOOP < 1 || NUM_SNOOP > 16 || MAX_HOLD < 1) begin : g_bad_params
    $error("coherent_bus_arbiter: parameter out of range");
  end

  // Sampled request copies: every decision is made from these, not the raw pins
  logic [NUM_PROC-1:0]  preq_q;
  logic [NUM_SNOOP-1:0] sreq_q;
  logic                 mreq_q;

  arb_state_t           state, state_n;
  logic [PW-1:0]        rr_ptr, rr_ptr_n;
  logic [SW-1:0]        snoop_ptr, snoop_ptr_n;
  logic [TW-1:0]        turn_cnt, turn_cnt_n;
  logic [NUM_PROC-1:0]  proc_gnt_n;
  logic [NUM_SNOOP-1:0] snoop_gnt_n;
  logic                 mem_gnt_n, busy_n;
  logic [PW-1:0]        owner_id_n;

  logic [NUM_PROC-1:0]  p_oh;
  logic [PW-1:0]        p_idx, p_next, owner_next;
  logic                 p_any;
  logic [NUM_SNOOP-1:0] s_oh;
  logic [SW-1:0]        s_idx, s_next;
  logic                 s_any;
  logic                 owner_req, revoke;

  rr_picker #(.WIDTH(NUM_PROC)) u_proc_pick (
    .req(preq_q), .ptr(rr_ptr), .gnt_onehot(p_oh), .gnt_idx(p_idx), .any(p_any)
  );

  rr_picker #(.WIDTH(NUM_SNOOP)) u_snoop_pick (
    .req(sreq_q), .ptr(snoop_ptr), .gnt_onehot(s_oh), .gnt_idx(s_idx), .any(s_any)
  );

  assign p_next     = (p_idx == PW'(NUM_PROC - 1)) ? '0 : p_idx + 1'b1;
  assign owner_next = (owner_id == PW'(NUM_PROC - 1)) ? '0 : owner_id + 1'b1;
  assign s_next     = (s_idx == SW'(NUM_SNOOP - 1)) ? '0 : s_idx + 1'b1;
  assign owner_req  = preq_q[owner_id];

`ifdef COHERENT_ARB_TIMEOUT_EN
  localparam int HW = idx_w(MAX_HOLD);

  logic [HW-1:0] hold_cnt;
  logic          in_own;

  assign in_own = (state == PROC) || (state == PROC_SNOOP) || (state == PROC_MEM);
  assign revoke = in_own && owner_req && (hold_cnt == HW'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt     <= '0;
      hold_timeout <= 1'b0;
    end else begin
      hold_cnt     <= (in_own && !revoke) ? hold_cnt + 1'b1 : '0;
      hold_timeout <= revoke;
    end
  end
`else
  assign revoke       = 1'b0;
  assign hold_timeout = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    snoop_ptr_n = snoop_ptr;
    turn_cnt_n  = turn_cnt;
    proc_gnt_n  = proc_gnt;
    snoop_gnt_n = snoop_gnt;
    mem_gnt_n   = mem_snoop_gnt;
    busy_n      = bus_busy;
    owner_id_n  = owner_id;
    unique case (state)
      IDLE: begin
        if (p_any) begin
          state_n    = PROC;
          proc_gnt_n = p_oh;
          owner_id_n = p_idx;
          rr_ptr_n   = p_next;
          busy_n     = 1'b1;
        end
      end
      PROC, PROC_SNOOP, PROC_MEM: begin
        // Owner release outranks any data-supply activity in the same cycle
        if (!owner_req || revoke) begin
          state_n     = TURN;
          turn_cnt_n  = '0;
          proc_gnt_n  = '0;
          snoop_gnt_n = '0;
          mem_gnt_n   = 1'b0;
          busy_n      = 1'b0;
          if (revoke) rr_ptr_n = owner_next;
        end else if (state == PROC) begin
          if (s_any) begin
            state_n     = PROC_SNOOP;
            snoop_gnt_n = s_oh;
            snoop_ptr_n = s_next;
          end else if (mreq_q) begin
            state_n   = PROC_MEM;
            mem_gnt_n = 1'b1;
          end
        end else if (state == PROC_SNOOP) begin
          if (!(|(sreq_q & snoop_gnt))) begin
            state_n     = PROC;
            snoop_gnt_n = '0;
          end
        end else if (!mreq_q) begin
          state_n   = PROC;
          mem_gnt_n = 1'b0;
        end
      end
      TURN: begin
        if (turn_cnt == TW'(TURN_CYCLES - 1)) state_n = IDLE;
        else turn_cnt_n = turn_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      preq_q        <= '0;
      sreq_q        <= '0;
      mreq_q        <= 1'b0;
      state         <= IDLE;
      rr_ptr        <= '0;
      snoop_ptr     <= '0;
      turn_cnt      <= '0;
      proc_gnt      <= '0;
      snoop_gnt     <= '0;
      mem_snoop_gnt <= 1'b0;
      bus_busy      <= 1'b0;
      owner_id      <= '0;
    end else begin
      preq_q        <= proc_req;
      sreq_q        <= snoop_req;
      mreq_q        <= mem_snoop_req;
      state         <= state_n;
      rr_ptr        <= rr_ptr_n;
      snoop_ptr     <= snoop_ptr_n;
      turn_cnt      <= turn_cnt_n;
      proc_gnt      <= proc_gnt_n;
      snoop_gnt     <= snoop_gnt_n;
      mem_snoop_gnt <= mem_gnt_n;
      bus_busy      <= busy_n;
      owner_id      <= owner_id_n;
    end
  end

endmodule
